// File: rtl/wash_pkg.sv
// Shared washing-machine stage encodings and scheduler state type.
// Used by the machine model and by wash_scheduler / wash_rr_arbiter.
package wash_pkg;

  localparam logic [2:0] STG_IDLE  = 3'd0;
  localparam logic [2:0] STG_FILL  = 3'd1;
  localparam logic [2:0] STG_WASH  = 3'd2;
  localparam logic [2:0] STG_RINSE = 3'd3;
  localparam logic [2:0] STG_SPIN  = 3'd4;
  localparam logic [2:0] STG_DONE  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_RUN    = 3'd2,
    S_FINISH = 3'd3,
    S_FAULT  = 3'd4
  } sched_state_e;

endpackage

// File: rtl/wash_rr_arbiter.sv
// Combinational round-robin picker: search begins at ptr+1 and wraps modulo N_REQ.
// Zero latency; no backpressure, the winner is valid whenever any_o is high.
module wash_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic             any_o
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = PTR_W'((int'(ptr_i) + off) % N_REQ);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/wash_scheduler.sv
// Round-robin sharing of one washing machine among N_REQ requesters; outputs decode state+grant registers.
// Optional START/RUN watchdog and FAULT state enabled by WASH_SCHED_WDT_EN.
module wash_scheduler
  import wash_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int START_TO = 8,
  parameter int RUN_TO   = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic             supply_i,
  input  logic [2:0]       stage_i,
  input  logic             fault_clr_i,
  output logic             cycle_o,
  output logic [N_REQ-1:0] grant_o,
  output logic [N_REQ-1:0] done_o,
  output logic             busy_o,
  output logic             fault_o
);

  localparam int PTR_W = $clog2(N_REQ);

  sched_state_e     state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] owner_idx;
  logic [N_REQ-1:0] win;
  logic             any_req;

  wash_rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_arb (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (win),
    .any_o (any_req)
  );

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) owner_idx = PTR_W'(i);
    end
  end

`ifdef WASH_SCHED_WDT_EN
  localparam int WDT_W = $clog2(RUN_TO + 1);
  logic [WDT_W-1:0] wdt_q, wdt_d;
  logic             start_hit, run_hit;

  assign start_hit = (int'(wdt_q) + 1 >= START_TO);
  assign run_hit   = (int'(wdt_q) + 1 >= RUN_TO);
`else
  localparam int unused_timeouts = START_TO + RUN_TO;
  logic unused_fault_clr;
  assign unused_fault_clr = fault_clr_i;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      S_IDLE: begin
        if (supply_i && any_req) begin
          grant_d = win;
          state_d = S_START;
        end
      end
      S_START: begin
        // An abandoned start is only possible before the machine has left IDLE.
        if (stage_i == STG_IDLE && !(|(req_i & grant_q))) begin
          grant_d = '0;
          state_d = S_IDLE;
        end else if (stage_i != STG_IDLE) begin
          state_d = S_RUN;
        end
`ifdef WASH_SCHED_WDT_EN
        else if (supply_i && start_hit) begin
          state_d = S_FAULT;
        end
`endif
      end
      S_RUN: begin
        if (stage_i == STG_DONE) begin
          state_d = S_FINISH;
        end
`ifdef WASH_SCHED_WDT_EN
        else if (supply_i && run_hit) begin
          state_d = S_FAULT;
        end
`endif
      end
      S_FINISH: begin
        ptr_d   = owner_idx;
        grant_d = '0;
        state_d = S_IDLE;
      end
      S_FAULT: begin
`ifdef WASH_SCHED_WDT_EN
        // grant_q still holds the faulted owner so it becomes the new pointer.
        if (fault_clr_i) begin
          ptr_d   = owner_idx;
          grant_d = '0;
          state_d = S_IDLE;
        end
`endif
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef WASH_SCHED_WDT_EN
  always_comb begin
    wdt_d = wdt_q;
    if (state_d != state_q) begin
      wdt_d = '0;
    end else if (supply_i && (wdt_q != {WDT_W{1'b1}})) begin
      wdt_d = wdt_q + {{(WDT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) wdt_q <= '0;
    else       wdt_q <= wdt_d;
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= PTR_W'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign cycle_o = (state_q == S_START);
  assign busy_o  = (state_q == S_START) || (state_q == S_RUN) || (state_q == S_FINISH);
  assign grant_o = (state_q == S_FAULT) ? '0 : grant_q;
  assign done_o  = (state_q == S_FINISH) ? grant_q : '0;
`ifdef WASH_SCHED_WDT_EN
  assign fault_o = (state_q == S_FAULT);
`else
  assign fault_o = 1'b0;
`endif

endmodule

// File: tb/tb_wash_scheduler.sv
// Directed bench for wash_scheduler; the washing machine's stage output is driven by hand.
// Watchdog scenarios adapt to whether WASH_SCHED_WDT_EN is defined.
module tb_wash_scheduler;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       supply;
  logic [2:0] stage;
  logic       fault_clr;
  logic       cycle;
  logic [3:0] grant;
  logic [3:0] done;
  logic       busy;
  logic       fault;

  int npass = 0;
  int ntot  = 0;
  int nfail = 0;

  wash_scheduler #(.N_REQ(4), .START_TO(8), .RUN_TO(64)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .supply_i    (supply),
    .stage_i     (stage),
    .fault_clr_i (fault_clr),
    .cycle_o     (cycle),
    .grant_o     (grant),
    .done_o      (done),
    .busy_o      (busy),
    .fault_o     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full job, starting with the IDLE edge that grants g. Supply may drop mid-WASH.
  task automatic do_job(input logic [3:0] g, input int wash, input int drop);
    step;
    chk("grant", {28'd0, grant}, {28'd0, g});
    chk("cycle_k", {31'd0, cycle}, 32'd1);
    step;
    chk("cycle_k1", {31'd0, cycle}, 32'd1);
    stage = 3'd1;
    step;
    chk("cycle_fall", {31'd0, cycle}, 32'd0);
    chk("busy_run", {31'd0, busy}, 32'd1);
    stage = 3'd2;
    repeat (wash / 2) step;
    if (drop > 0) begin
      supply = 1'b0;
      repeat (drop) step;
      chk("drop_fault", {31'd0, fault}, 32'd0);
      chk("drop_done", {28'd0, done}, 32'd0);
      chk("drop_busy", {31'd0, busy}, 32'd1);
      supply = 1'b1;
    end
    repeat (wash - wash / 2) step;
    stage = 3'd3;
    step;
    stage = 3'd4;
    step;
    stage = 3'd5;
    step;
    chk("done_pulse", {28'd0, done}, {28'd0, g});
    chk("fault_none", {31'd0, fault}, 32'd0);
    stage = 3'd0;
    step;
    chk("done_clear", {28'd0, done}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("grant_clear", {28'd0, grant}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; req = 4'd0; supply = 1'b0; stage = 3'd0; fault_clr = 1'b0;
    step;
    chk("rst_grant", {28'd0, grant}, 32'd0);
    chk("rst_cycle", {31'd0, cycle}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {28'd0, done}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    rst = 1'b0;
    step;

    // Single requester, single job.
    req = 4'b0001; supply = 1'b1;
    do_job(4'b0001, 3, 0);
    req = 4'b0000;
    step;

    // All requesting: strict rotation from requester 0 after reset, one IDLE cycle between jobs.
    rst = 1'b1; step; rst = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      do_job(4'b0001 << (i % 4), 2, 0);
    end
    req = 4'b0000;
    step;

    // Supply lost during WASH: 52 supply-high RUN cycles plus 20 frozen ones, no timeout.
    rst = 1'b1; step; rst = 1'b0;
    req = 4'b0001;
    do_job(4'b0001, 50, 20);
    req = 4'b0000;
    step;

    // Machine stuck in WASH.
    rst = 1'b1; step; rst = 1'b0;
    req = 4'b0011;
    step;
    chk("stuck_grant", {28'd0, grant}, 32'd1);
    step;
    stage = 3'd1;
    step;
    stage = 3'd2;
    repeat (63) step;
    chk("wdt_63_fault", {31'd0, fault}, 32'd0);
    chk("wdt_63_busy", {31'd0, busy}, 32'd1);
    step;
`ifdef WASH_SCHED_WDT_EN
    chk("wdt_64_fault", {31'd0, fault}, 32'd1);
    chk("wdt_64_grant", {28'd0, grant}, 32'd0);
    chk("wdt_64_busy", {31'd0, busy}, 32'd0);
    chk("wdt_64_cycle", {31'd0, cycle}, 32'd0);
    stage = 3'd0;
    step;
    chk("fault_hold", {31'd0, fault}, 32'd1);
    fault_clr = 1'b1;
    step;
    fault_clr = 1'b0;
    chk("clr_fault", {31'd0, fault}, 32'd0);
    chk("clr_grant", {28'd0, grant}, 32'd0);
    chk("clr_busy", {31'd0, busy}, 32'd0);
`else
    chk("nowdt_fault", {31'd0, fault}, 32'd0);
    chk("nowdt_grant", {28'd0, grant}, 32'd1);
    chk("nowdt_busy", {31'd0, busy}, 32'd1);
    stage = 3'd5;
    step;
    chk("nowdt_done", {28'd0, done}, 32'd1);
    stage = 3'd0;
    step;
`endif
    step;
    chk("skip_faulted", {28'd0, grant}, 32'd2);
    chk("skip_cycle", {31'd0, cycle}, 32'd1);

    // Requester 1 abandons during START while stage is still IDLE.
    req = 4'b0000;
    step;
    chk("abort_grant", {28'd0, grant}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {28'd0, done}, 32'd0);
    step;
    chk("abort_nodone", {28'd0, done}, 32'd0);

    // ptr untouched by the abort, so requester 1 wins again; drop in RUN is ignored.
    req = 4'b0011;
    step;
    chk("rerun_grant", {28'd0, grant}, 32'd2);
    step;
    stage = 3'd1;
    step;
    req = 4'b0000;
    stage = 3'd2;
    step;
    chk("run_drop_busy", {31'd0, busy}, 32'd1);
    stage = 3'd5;
    step;
    chk("run_drop_done", {28'd0, done}, 32'd2);
    stage = 3'd0;
    step;

    // Reset in the middle of RUN.
    req = 4'b0100;
    step;
    chk("pre_rst_grant", {28'd0, grant}, 32'd4);
    step;
    stage = 3'd1;
    step;
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_grant", {28'd0, grant}, 32'd0);
    chk("arst_cycle", {31'd0, cycle}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {28'd0, done}, 32'd0);
    chk("arst_fault", {31'd0, fault}, 32'd0);
    stage = 3'd0;
    step;
    rst = 1'b0;
    req = 4'b1111;
    step;
    chk("post_rst_grant", {28'd0, grant}, 32'd1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
